alu_issue_ctrl: RTL and testbench

Upstream issue stage for the 8-bit combinational ALU. It accepts register-to-register instructions over a valid/ready handshake and holds a 4-entry x 8-bit register file. It drives the ALU operand and opcode inputs, captures the ALU result one cycle later, and writes it back. The captured result is also presented downstream over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl_if.sv | 23 ++
 rtl/alu_issue_ctrl.sv | 117 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction and result handshakes between the issue controller and its neighbours.
// master = upstream/downstream side, slave = alu_issue_ctrl.
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        instr;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_rd;

    modport master (
        output in_valid, instr, res_ready,
        input  in_ready, res_valid, res_data, res_rd
    );

    modport slave (
        input  in_valid, instr, res_ready,
        output in_ready, res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: 4-entry register file, IDLE/ISSUE/RESP FSM.
// Define ALU_ISSUE_BYPASS_EN to accept a new instruction straight out of RESP (1 instr / 2 cycles).
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   io,
    input  logic              ld_en,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    state_t                        state_q, state_d;
    instr_t                        ins_q, ins_d;
    logic [NREG-1:0][DATA_W-1:0]   rf_q, rf_d;
    logic [DATA_W-1:0]             a_hold_q, a_hold_d;
    logic [DATA_W-1:0]             b_hold_q, b_hold_d;
    logic [DATA_W-1:0]             res_data_q, res_data_d;
    logic [1:0]                    res_rd_q, res_rd_d;
    logic                          res_valid_q, res_valid_d;
    logic                          in_ready;
    logic                          accept;

`ifdef ALU_ISSUE_BYPASS_EN
    assign in_ready = (state_q == IDLE) || ((state_q == RESP) && io.res_ready);
`else
    assign in_ready = (state_q == IDLE);
`endif
    assign accept = io.in_valid && in_ready;

    // Operands read the register file live during ISSUE; rf_q already holds any write
    // committed on the accepting edge, and nothing else can land until the closing edge.
    assign alu_a    = (state_q == ISSUE) ? rf_q[ins_q.rs1] : a_hold_q;
    assign alu_b    = (state_q == ISSUE) ? rf_q[ins_q.rs2] : b_hold_q;
    assign alu_ctrl = ins_q.op;

    assign io.in_ready  = in_ready;
    assign io.res_valid = res_valid_q;
    assign io.res_data  = res_data_q;
    assign io.res_rd    = res_rd_q;

    always_comb begin
        state_d     = state_q;
        ins_d       = ins_q;
        rf_d        = rf_q;
        a_hold_d    = alu_a;
        b_hold_d    = alu_b;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_valid_d = res_valid_q;

        if (ld_en)
            rf_d[ld_addr] = ld_data;

        case (state_q)
            ISSUE: begin
                // Writeback is applied after the load so it wins on an address clash.
                rf_d[ins_q.rd] = alu_result;
                res_data_d     = alu_result;
                res_rd_d       = ins_q.rd;
                res_valid_d    = 1'b1;
                state_d        = RESP;
            end
            RESP: begin
                if (io.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            ins_d       = instr_t'(io.instr);
            res_valid_d = 1'b0;
            state_d     = ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ins_q       <= '0;
            rf_q        <= '0;
            a_hold_q    <= '0;
            b_hold_q    <= '0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ins_q       <= ins_d;
            rf_q        <= rf_d;
            a_hold_q    <= a_hold_d;
            b_hold_q    <= b_hold_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
// ALU op codes assumed: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_ctrl;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    alu_issue_ctrl_if #(.DATA_W(8)) bus ();

    alu_issue_ctrl #(.DATA_W(8), .NREG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io         (bus.slave),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    always_comb begin
        case (alu_ctrl)
            3'd0:    alu_result = alu_a + alu_b;
            3'd1:    alu_result = alu_a - alu_b;
            3'd2:    alu_result = alu_a & alu_b;
            3'd3:    alu_result = alu_a | alu_b;
            3'd4:    alu_result = alu_a ^ alu_b;
            default: alu_result = alu_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // Accept in IDLE, one ISSUE cycle, result visible in RESP; res_ready high returns to IDLE.
    task automatic run(input string tag, input logic [8:0] ins, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] eres);
        bus.in_valid = 1'b1; bus.instr = ins;
        chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk({tag, ".in_ready_issue"}, 32'(bus.in_ready), 32'd0);
        chk({tag, ".alu_a"}, 32'(alu_a), 32'(ea));
        chk({tag, ".alu_b"}, 32'(alu_b), 32'(eb));
        chk({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'(ins[8:6]));
        tick();
        chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'd1);
        chk({tag, ".res_data"}, 32'(bus.res_data), 32'(eres));
        chk({tag, ".res_rd"}, 32'(bus.res_rd), 32'(ins[5:4]));
        tick();
        chk({tag, ".res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    endtask

    // AND r,r,r returns rf[r] and rewrites it unchanged.
    task automatic read_reg(input string tag, input logic [1:0] r, input logic [7:0] v);
        run(tag, {3'b010, r, r, r}, v, v, v);
    endtask

    logic [8:0] seq_ins [3];
    logic [7:0] seq_res [3];

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.in_valid = 1'b0; bus.instr = '0; bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst.res_data", 32'(bus.res_data), 32'd0);
        chk("rst.res_rd", 32'(bus.res_rd), 32'd0);
        chk("rst.alu_a", 32'(alu_a), 32'd0);
        chk("rst.alu_b", 32'(alu_b), 32'd0);
        chk("rst.alu_ctrl", 32'(alu_ctrl), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        read_reg("rst.r3", 2'd3, 8'h00);

        // ADD rd=2 rs1=0 rs2=1
        load(2'd0, 8'h01); load(2'd1, 8'h01);
        run("add", 9'b000_10_00_01, 8'h01, 8'h01, 8'h02);
        read_reg("add.r2", 2'd2, 8'h02);

        // SUB then dependent ADD with no stall
        load(2'd0, 8'h04); load(2'd1, 8'h01);
        run("sub", 9'b001_11_00_01, 8'h04, 8'h01, 8'h03);
        run("dep", 9'b000_00_11_01, 8'h03, 8'h01, 8'h04);
        read_reg("dep.r0", 2'd0, 8'h04);

        // AND/OR/XOR streamed with in_valid held high
        load(2'd0, 8'h0C); load(2'd1, 8'h05);
        seq_ins[0] = 9'b010_10_00_01; seq_res[0] = 8'h04;
        seq_ins[1] = 9'b011_10_00_01; seq_res[1] = 8'h0D;
        seq_ins[2] = 9'b100_10_00_01; seq_res[2] = 8'h09;
        bus.in_valid = 1'b1; bus.instr = seq_ins[0];
        for (int i = 0; i < 3; i++) begin
            chk("stream.in_ready_acc", 32'(bus.in_ready), 32'd1);
            tick();
            chk("stream.in_ready_issue", 32'(bus.in_ready), 32'd0);
            if (i < 2) bus.instr = seq_ins[i+1];
            else       bus.in_valid = 1'b0;
            tick();
            chk("stream.res_valid", 32'(bus.res_valid), 32'd1);
            chk("stream.res_data", 32'(bus.res_data), 32'(seq_res[i]));
`ifdef ALU_ISSUE_BYPASS_EN
            chk("stream.in_ready_resp", 32'(bus.in_ready), 32'd1);
`else
            chk("stream.in_ready_resp", 32'(bus.in_ready), 32'd0);
            if (i < 2) tick();
`endif
        end
        tick();
        chk("stream.idle", 32'(bus.res_valid), 32'd0);

        // Backpressure: OR rd=3 -> 0x0D held while res_ready low, XOR rd=0 waiting
        bus.res_ready = 1'b0;
        bus.in_valid = 1'b1; bus.instr = 9'b011_11_00_01;
        tick();
        bus.instr = 9'b100_00_00_01;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp.res_valid", 32'(bus.res_valid), 32'd1);
            chk("bp.res_data", 32'(bus.res_data), 32'h0D);
            chk("bp.res_rd", 32'(bus.res_rd), 32'd3);
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
`ifndef ALU_ISSUE_BYPASS_EN
        tick();
        chk("bp.released_idle", 32'(bus.res_valid), 32'd0);
        chk("bp.released_ready", 32'(bus.in_ready), 32'd1);
`endif
        tick();
        bus.in_valid = 1'b0;
        chk("bp.next_issue", 32'(alu_ctrl), 32'd4);
        tick();
        chk("bp.next_res", 32'(bus.res_data), 32'h09);
        chk("bp.next_rd", 32'(bus.res_rd), 32'd0);
        tick();

        // Collision: load on the writeback edge, same and different address
        load(2'd0, 8'h01); load(2'd1, 8'h01);
        bus.in_valid = 1'b1; bus.instr = 9'b000_10_00_01;
        tick();
        bus.in_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd2; ld_data = 8'hAA;
        tick();
        ld_en = 1'b0;
        chk("coll_same.res", 32'(bus.res_data), 32'h02);
        tick();
        read_reg("coll_same.r2", 2'd2, 8'h02);
        load(2'd2, 8'h55);
        bus.in_valid = 1'b1; bus.instr = 9'b000_10_00_01;
        tick();
        bus.in_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
        tick();
        ld_en = 1'b0;
        chk("coll_diff.res", 32'(bus.res_data), 32'h02);
        tick();
        read_reg("coll_diff.r1", 2'd1, 8'hAA);
        read_reg("coll_diff.r2", 2'd2, 8'h02);

        // Load landing on the accepting edge is seen by ISSUE: R0=0x10, R1=0xAA
        ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h10;
        run("ld_accept", 9'b000_11_00_01, 8'h10, 8'hAA, 8'hBA);
        ld_en = 1'b0;

        // Reset during ISSUE aborts without writeback
        bus.in_valid = 1'b1; bus.instr = 9'b000_11_00_01;
        tick();
        bus.in_valid = 1'b0;
        chk("abort.in_issue", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.res_valid", 32'(bus.res_valid), 32'd0);
        chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort.res_data", 32'(bus.res_data), 32'd0);
        chk("abort.alu_a", 32'(alu_a), 32'd0);
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        tick();
        read_reg("abort.r3", 2'd3, 8'h00);
        read_reg("abort.r1", 2'd1, 8'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
